// File: rtl/axil_pkg.sv
// Shared AXI4-Lite response codes, slave FSM state types and the
// memory-handshake constants used by both the LSU master and its slaves.
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} wr_state_t;

  // Master-side memory handshake phases, kept here so master and slave agree.
  localparam logic [1:0] MEM_WAIT_REQ = 2'd0;
  localparam logic [1:0] MEM_BUSY     = 2'd1;
  localparam logic [1:0] MEM_WAIT_RES = 2'd2;

endpackage

// File: rtl/lsu_sram_slave_lfsr8.sv
// 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1), free running outside reset.
// Shared by the latency-injecting memory slaves as their delay source.
module lfsr8 (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] seed,
  output logic [7:0] out
);

  logic fb;

  assign fb = out[7] ^ out[5] ^ out[4] ^ out[3];

  // Load the seed in reset, otherwise shift one step per cycle.
  always_ff @(posedge clk) begin
    if (rst) out <= seed;
    else     out <= {out[6:0], fb};
  end

endmodule

// File: rtl/lsu_sram_slave.sv
// Data-memory slave behind the LSU: independent AXI4-Lite read and write
// engines over a byte-strobed word array, with fixed or LFSR-driven latency.
module lsu_sram_slave
  import axil_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          DEPTH     = 4096,
  parameter int          RD_DELAY  = 0,
  parameter int          WR_DELAY  = 0,
  parameter int          RAND_EN   = 0,
  parameter int          RAND_BITS = 4,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        arvalid,
  output logic        arready,
  input  logic [31:0] araddr,
  output logic        rvalid,
  input  logic        rready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] awaddr,
  input  logic        wvalid,
  output logic        wready,
  input  logic [31:0] wdata,
  input  logic [7:0]  wstrb,
  output logic        bvalid,
  input  logic        bready,
  output logic [1:0]  bresp
);

  localparam int DATA_W = 32;
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Unsigned 32-bit offset: addresses below the base wrap to huge indices
  // and fall out of range instead of aliasing into the array.
  function automatic logic in_range(input logic [31:0] addr);
    return (addr >= BASE_ADDR) && (((addr - BASE_ADDR) >> 2) < 32'(DEPTH));
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] addr);
    return IDX_W'((addr - BASE_ADDR) >> 2);
  endfunction

  logic [DATA_W-1:0] mem [DEPTH];
  logic [7:0]        lfsr;
  logic [31:0]       rd_delay, wr_delay;

  rd_state_t         rd_state, rd_state_n;
  logic [31:0]       rd_cnt, rd_cnt_n;
  logic [31:0]       rd_addr;
  logic              rd_accept, rd_capture, arready_n, rvalid_n;

  wr_state_t         wr_state, wr_state_n;
  logic [31:0]       wr_cnt, wr_cnt_n;
  logic [31:0]       wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [3:0]        wr_strb;
  logic              wr_rdy, wr_rdy_n, wr_accept, wr_commit, bvalid_n;

  logic              unused_bits;

  assign unused_bits = ^{wstrb[7:4], lfsr};
  assign awready     = wr_rdy;
  assign wready      = wr_rdy;

  lfsr8 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .seed (LFSR_SEED),
    .out  (lfsr)
  );

  assign rd_delay = (RAND_EN != 0) ? 32'(lfsr[RAND_BITS-1:0]) : 32'(RD_DELAY);
  assign wr_delay = (RAND_EN != 0) ? 32'(lfsr[RAND_BITS-1:0]) : 32'(WR_DELAY);

  // Read engine next state: accept, count down the delay, hold the response.
  always_comb begin
    rd_state_n = rd_state;
    rd_cnt_n   = rd_cnt;
    arready_n  = arready;
    rvalid_n   = rvalid;
    rd_accept  = 1'b0;
    rd_capture = 1'b0;
    case (rd_state)
      R_IDLE: begin
        arready_n = 1'b1;
        if (arvalid && arready) begin
          rd_accept  = 1'b1;
          arready_n  = 1'b0;
          rd_cnt_n   = rd_delay;
          rd_state_n = R_WAIT;
        end
      end
      R_WAIT: begin
        if (rd_cnt == 32'd0) begin
          rd_capture = 1'b1;
          rvalid_n   = 1'b1;
          rd_state_n = R_RESP;
        end else begin
          rd_cnt_n = rd_cnt - 32'd1;
        end
      end
      R_RESP: begin
        if (rvalid && rready) begin
          rvalid_n   = 1'b0;
          arready_n  = 1'b1;
          rd_state_n = R_IDLE;
        end
      end
      default: rd_state_n = R_IDLE;
    endcase
  end

  // Read engine registers; rdata/rresp only change on capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state <= R_IDLE;
      rd_cnt   <= '0;
      arready  <= 1'b0;
      rvalid   <= 1'b0;
      rdata    <= '0;
      rresp    <= RESP_OKAY;
    end else begin
      rd_state <= rd_state_n;
      rd_cnt   <= rd_cnt_n;
      arready  <= arready_n;
      rvalid   <= rvalid_n;
      if (rd_capture) begin
        rdata <= in_range(rd_addr) ? mem[word_idx(rd_addr)] : '0;
        rresp <= in_range(rd_addr) ? RESP_OKAY : RESP_DECERR;
      end
    end
  end

  // Write engine next state: address and data must arrive together.
  always_comb begin
    wr_state_n = wr_state;
    wr_cnt_n   = wr_cnt;
    wr_rdy_n   = wr_rdy;
    bvalid_n   = bvalid;
    wr_accept  = 1'b0;
    wr_commit  = 1'b0;
    case (wr_state)
      W_IDLE: begin
        wr_rdy_n = 1'b1;
        if (awvalid && wvalid && wr_rdy) begin
          wr_accept  = 1'b1;
          wr_rdy_n   = 1'b0;
          wr_cnt_n   = wr_delay;
          wr_state_n = W_WAIT;
        end
      end
      W_WAIT: begin
        if (wr_cnt == 32'd0) begin
          wr_commit  = 1'b1;
          bvalid_n   = 1'b1;
          wr_state_n = W_RESP;
        end else begin
          wr_cnt_n = wr_cnt - 32'd1;
        end
      end
      W_RESP: begin
        if (bvalid && bready) begin
          bvalid_n   = 1'b0;
          wr_rdy_n   = 1'b1;
          wr_state_n = W_IDLE;
        end
      end
      default: wr_state_n = W_IDLE;
    endcase
  end

  // Write engine registers; bresp only changes on commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state <= W_IDLE;
      wr_cnt   <= '0;
      wr_rdy   <= 1'b0;
      bvalid   <= 1'b0;
      bresp    <= RESP_OKAY;
    end else begin
      wr_state <= wr_state_n;
      wr_cnt   <= wr_cnt_n;
      wr_rdy   <= wr_rdy_n;
      bvalid   <= bvalid_n;
      if (wr_commit) bresp <= in_range(wr_addr) ? RESP_OKAY : RESP_DECERR;
    end
  end

  // Request payload capture at the accept edge (data path, never reset).
  always_ff @(posedge clk) begin
    if (rd_accept) rd_addr <= araddr;
    if (wr_accept) begin
      wr_addr <= awaddr;
      wr_data <= wdata;
      wr_strb <= wstrb[3:0];
    end
  end

  // Byte-strobed commit; reset on the commit edge cancels the write, and a
  // read captured on the same edge still sees the old word.
  always_ff @(posedge clk) begin
    if (!rst && wr_commit && in_range(wr_addr)) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_strb[b]) mem[word_idx(wr_addr)][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

endmodule

// File: doc/lsu_sram_slave.md
Name: lsu_sram_slave

Overview:
- AXI4-Lite-style data-memory slave directly downstream of the write-back/LSU stage.
- Consumes that stage's ar/r/aw/w/b channels and returns load data and write acknowledgements.
- Has independent read and write engines, a configurable response latency (fixed or pseudo-random) and byte-strobed word storage.
- Used as the data memory in simulation and in the FPGA build.

Parameters:
- BASE_ADDR, 32'h8000_0000, byte address of word 0
- DEPTH, 4096, number of 32-bit words
- RD_DELAY, 0, fixed extra read-latency cycles when RAND_EN=0
- WR_DELAY, 0, fixed extra write-latency cycles when RAND_EN=0
- RAND_EN, 0, 1 = per-transaction latency taken from LFSR
- RAND_BITS, 4, LFSR bits used as delay when RAND_EN=1 (max 2^RAND_BITS-1)
- LFSR_SEED, 8'hA5, non-zero LFSR reset value

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- arvalid  in  1  read address valid
- arready  out  1  read address ready
- araddr  in  32  read byte address
- rvalid  out  1  read data valid
- rready  in  1  read data ready
- rdata  out  32  full aligned word
- rresp  out  2  read response
- awvalid  in  1  write address valid
- awready  out  1  write address ready
- awaddr  in  32  write byte address
- wvalid  in  1  write data valid
- wready  out  1  write data ready
- wdata  in  32  write data, pre-shifted to byte lanes
- wstrb  in  8  byte strobes; [3:0] used, [7:4] ignored
- bvalid  out  1  write response valid
- bready  in  1  write response ready
- bresp  out  2  write response

Behaviour:
- Reset values: arready=0, awready=0, wready=0, rvalid=0, bvalid=0, rdata=0, rresp=OKAY, bresp=OKAY, lfsr=LFSR_SEED, both FSMs IDLE.
  - arready, awready and wready rise on the first clk edge after rst deasserts.
  - Memory contents are not reset.
- Address decode: idx=(addr-BASE_ADDR)>>2.
  - In range iff addr>=BASE_ADDR and idx<DEPTH.
  - addr[1:0] is ignored; the master extracts sub-word bytes.
- Read FSM, states R_IDLE, R_WAIT, R_RESP:
  - R_IDLE: arready=1. On arvalid&&arready: latch araddr, arready<=0, cnt<=delay, go to R_WAIT.
  - R_WAIT: if cnt==0, capture rdata=mem[idx] (0 if out of range), rresp=OKAY or DECERR(2'b11), rvalid<=1, go to R_RESP. Otherwise cnt<=cnt-1.
  - R_RESP: hold rvalid, rdata and rresp until rvalid&&rready. On that edge rvalid<=0, arready<=1, go to R_IDLE.
  - Latency: rvalid is first high delay+2 cycles after the handshake edge.
- Write FSM, states W_IDLE, W_WAIT, W_RESP:
  - W_IDLE: awready=wready=1. Accept only when awvalid&&wvalid are both high in the same cycle; a lone awvalid or wvalid is not accepted.
  - On accept: latch awaddr, wdata and wstrb[3:0]; awready<=0, wready<=0; cnt<=delay; go to W_WAIT.
  - W_WAIT: when cnt==0, write the enabled bytes into mem[idx] (no write if out of range), bresp=OKAY or DECERR, bvalid<=1, go to W_RESP.
  - W_RESP: hold bvalid until bready. On that edge bvalid<=0, awready<=wready<=1, go to W_IDLE.
- Delay source: RAND_EN=0 uses RD_DELAY/WR_DELAY. RAND_EN=1 uses lfsr[RAND_BITS-1:0], sampled at the accept edge.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1. Advances every cycle when not in reset.
- Concurrency: the read and write engines are fully independent and may be in flight at the same time.
  - If the read capture and the write commit hit the same word on the same edge, the read returns the old data (read-before-write).
- Wrap: idx arithmetic is 32-bit unsigned. An address below BASE_ADDR underflows and therefore decodes out of range (DECERR), never aliasing into memory.
- Reset mid-transaction: any in-flight read/write is abandoned. A write not yet committed (still in W_WAIT) does not modify memory.
- Back-to-back: a new request is accepted no earlier than the cycle after the previous response handshake.

Decomposition:
- Package axil_pkg:
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10, RESP_DECERR=2'b11
  - rd_state_t {R_IDLE,R_WAIT,R_RESP}, wr_state_t {W_IDLE,W_WAIT,W_RESP}
  - MEM_WAIT_REQ/MEM_BUSY/MEM_WAIT_RES constants shared with the master
- Sub-module lfsr8: clk, rst, seed, out[7:0]. It is reused by other latency-injecting slaves.

Test Plan:
- Read after reset, RD_DELAY=0: preload mem[0]=32'hDEADBEEF, issue araddr=32'h8000_0000 with rready=1 → rvalid high 2 cycles after handshake, rdata=32'hDEADBEEF, rresp=00.
- Byte write: awaddr=wdata addr 32'h8000_0005, wdata=32'h0000_AB00, wstrb=8'h02, mem[1]=32'h1122_3344 → bvalid, bresp=00; a following read of 32'h8000_0004 returns 32'h1122_AB44.
- Out of range: read and write at 32'h7FFF_FFFC and at BASE+4*DEPTH → rresp=bresp=2'b11, rdata=0, memory unchanged.
- Backpressure with RD_DELAY=3: rready held 0 for 5 cycles after rvalid → rvalid and rdata stable throughout, arready stays 0; completes on the first rready=1 cycle.
- Simultaneous read and write to mem[2]=32'h0 (old value), write data 32'hCAFE_F00D, delays aligned so capture and commit share an edge → read returns 32'h0; a subsequent read returns 32'hCAFE_F00D.
- RAND_EN=1, 200 random loads/stores against a scoreboard: data always matches, latency ≤ 2^RAND_BITS+1. Assert rst mid-W_WAIT → the target word is unchanged and all valids are 0 the next cycle.
